data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data memory responder: word RAM, key input register and display register
// behind a three-state request/ready handshake with byte-lane access.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] KEY_ADDR    = 32'hFFFF_FF00,
   parameter logic [31:0] DISP_ADDR   = 32'hFFFF_FF04
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic        byte_acc,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [7:0]  key_in,
   output logic        busy,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err,
   output logic [31:0] disp
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic          byte_q, byte_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [31:0]   disp_q, disp_d;
   logic [7:0]    key_s1_q, key_s2_q;

   logic [31:0]   mem [DEPTH_WORDS];

   logic [1:0]    lane;
   logic [AW-1:0] idx;
   logic          hit_ram, hit_key, hit_disp;
   logic          misalign, acc_ok, in_access, ram_we;
   logic [31:0]   ram_word, src_word, shifted, rd_val;
   logic [31:0]   old_word, wmerge;

   // Address decode, read-lane selection and write-lane merge
   always_comb begin
      lane      = addr_q[1:0];
      idx       = addr_q[AW+1:2];
      hit_ram   = (addr_q[31:AW+2] == '0);
      hit_key   = (addr_q[31:2] == KEY_ADDR[31:2]);
      hit_disp  = (addr_q[31:2] == DISP_ADDR[31:2]);
      misalign  = !byte_q && (lane != 2'b00);
      acc_ok    = !misalign && (hit_ram || hit_key || hit_disp);
      in_access = (state_q == ACCESS);
      ram_word  = mem[idx];
      src_word  = 32'h0;
      unique case (1'b1)
         hit_ram:  src_word = ram_word;
         hit_disp: src_word = disp_q;
         hit_key:  src_word = {24'h0, key_s2_q};
         default:  src_word = 32'h0;
      endcase
      shifted  = src_word >> {lane, 3'b000};
      rd_val   = byte_q ? {24'h0, shifted[7:0]} : src_word;
      old_word = hit_disp ? disp_q : ram_word;
      wmerge   = wdata_q;
      if (byte_q) begin
         wmerge = old_word;
         wmerge[{lane, 3'b000} +: 8] = wdata_q[7:0];
      end
      ram_we = in_access && acc_ok && we_q && hit_ram;
   end

   // Next state, request latching and response capture
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      byte_d  = byte_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      disp_d  = disp_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = we;
               byte_d  = byte_acc;
               addr_d  = addr;
               wdata_d = wdata;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            err_d   = !acc_ok;
            rdata_d = (acc_ok && !we_q) ? rd_val : 32'h0;
            if (acc_ok && we_q && hit_disp) begin
               disp_d = wmerge;
            end
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control, response and synchronizer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         byte_q   <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
         disp_q   <= 32'h0;
         key_s1_q <= 8'h0;
         key_s2_q <= 8'h0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         byte_q   <= byte_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         disp_q   <= disp_d;
         key_s1_q <= key_in;
         key_s2_q <= key_s1_q;
      end
   end

   // RAM array keeps its contents through reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[idx] <= wmerge;
      end
   end

   assign busy  = (state_q != IDLE);
   assign ready = (state_q == RESP);
   assign rdata = rdata_q;
   assign err   = err_q;
   assign disp  = disp_q;

endmodule
